// File: rtl/regmax_coord_streamer.sv
// regmax_coord_streamer
//   Drain side of the regional-maximum result bitmap. On a start pulse the
//   M x N bitmap is copied into a shadow register, scanned row-major one bit
//   per cycle, and the (row, col) of every set bit is streamed out over a
//   valid/ready interface. out_last marks the final coordinate, frame_done
//   pulses for one cycle when the frame is finished.
//
//   Optional feature (macro REGMAX_COORD_COUNT_EN): adds max_count, the
//   number of coordinates handed off in the current/last frame.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        capture-and-stream request (accepted in IDLE only)
//   regmax_image result bitmap, bit [i][j] = row i, column j
//   busy         high whenever the streamer is not idle
//   out_valid    coordinate beat valid
//   out_ready    downstream accepts the beat
//   out_i/out_j  row/column of the current maximum
//   out_last     current beat is the last one of the frame
//   frame_done   one-cycle end-of-frame pulse
//   max_count    (REGMAX_COORD_COUNT_EN only) handshakes in this frame
module regmax_coord_streamer #(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int I_WIDTH = 3,
  parameter int J_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [M-1:0][N-1:0]          regmax_image,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [I_WIDTH-1:0]           out_i,
  output logic [J_WIDTH-1:0]           out_j,
  output logic                         out_last,
  output logic                         frame_done
`ifdef REGMAX_COORD_COUNT_EN
  ,
  output logic [$clog2(M*N+1)-1:0]     max_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [M-1:0][N-1:0]   r_shadow;
  logic [I_WIDTH-1:0]    r_i;
  logic [J_WIDTH-1:0]    r_j;

  logic [M-1:0][N-1:0]   w_cleared;
  logic                  w_shadow_empty;
  logic                  w_cleared_empty;
  logic                  w_bit_set;
  logic                  w_j_wrap;
  logic [I_WIDTH-1:0]    w_i_next;
  logic [J_WIDTH-1:0]    w_j_next;

  // Shadow with the currently indexed bit removed: what remains after the
  // coordinate under the scan index has been emitted.
  always_comb begin
    w_cleared            = r_shadow;
    w_cleared[r_i][r_j]  = 1'b0;
  end

  assign w_shadow_empty  = (r_shadow == '0);
  assign w_cleared_empty = (w_cleared == '0);
  assign w_bit_set       = r_shadow[r_i][r_j];

  // Row-major index advance. Never wraps past the last element in a way
  // that matters: the shadow is empty by then and the FSM leaves the scan.
  assign w_j_wrap = (r_j == J_WIDTH'(N - 1));
  assign w_j_next = w_j_wrap ? '0 : r_j + J_WIDTH'(1);
  assign w_i_next = w_j_wrap ? r_i + I_WIDTH'(1) : r_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_i        <= '0;
      r_j        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_i      <= '0;
      out_j      <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
`ifdef REGMAX_COORD_COUNT_EN
      max_count  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            r_shadow <= regmax_image;
            r_i      <= '0;
            r_j      <= '0;
            busy     <= 1'b1;
            r_state  <= SCAN;
`ifdef REGMAX_COORD_COUNT_EN
            max_count <= '0;
`endif
          end
        end

        SCAN: begin
          if (w_shadow_empty) begin
            frame_done <= 1'b1;
            r_state    <= DONE;
          end else if (w_bit_set) begin
            out_i     <= r_i;
            out_j     <= r_j;
            out_valid <= 1'b1;
            out_last  <= w_cleared_empty;
            r_shadow  <= w_cleared;
            r_state   <= SEND;
          end else begin
            r_i <= w_i_next;
            r_j <= w_j_next;
          end
        end

        SEND: begin
          // Shadow already excludes the beat on the wire, so its emptiness
          // decides whether anything is left to scan.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            r_i       <= w_i_next;
            r_j       <= w_j_next;
`ifdef REGMAX_COORD_COUNT_EN
            max_count <= max_count + 1'b1;
`endif
            if (w_shadow_empty) begin
              frame_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= SCAN;
            end
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regmax_coord_streamer.sv
module tb_regmax_coord_streamer;

  localparam int M = 8;
  localparam int N = 8;

  logic                clk;
  logic                reset;
  logic                start;
  logic [M-1:0][N-1:0] regmax_image;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          out_i;
  logic [2:0]          out_j;
  logic                out_last;
  logic                frame_done;
`ifdef REGMAX_COORD_COUNT_EN
  logic [6:0]          max_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  regmax_coord_streamer #(.M(M), .N(N), .I_WIDTH(3), .J_WIDTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .regmax_image (regmax_image),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_i        (out_i),
    .out_j        (out_j),
    .out_last     (out_last),
    .frame_done   (frame_done)
`ifdef REGMAX_COORD_COUNT_EN
    ,
    .max_count    (max_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; afterwards we sit 1 time unit past the edge of cycle cyc.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference timeline built from the streaming rules: the scan examines one
  // bit per cycle starting the cycle after a start or a handshake, a set bit
  // at linear index k is presented the cycle after it is examined, and the
  // frame finishes the cycle after the last handshake (or two cycles after
  // start when nothing is set).
  task automatic run_frame(input logic [63:0] img, input int max_stall, input bit disturb);
    int ks[$];
    int vs[$];
    int hs[$];
    int t, resume, p, done_c, n_idx, s, v;
    t            = cyc;
    regmax_image = img;
    start        = 1'b1;
    out_ready    = 1'b1;
    resume = t + 1;
    p      = 0;
    for (int k = 0; k < M * N; k++) begin
      if (img[k]) begin
        v = resume + (k - p) + 1;
        s = int'($urandom_range(max_stall, 0));
        ks.push_back(k);
        vs.push_back(v);
        hs.push_back(v + s);
        resume = v + s + 1;
        p      = k + 1;
      end
    end
    done_c = (ks.size() == 0) ? t + 2 : resume;

    do begin
      step();
      start = 1'b0;
      if (disturb && cyc == t + 3) begin
        start        = 1'b1;
        regmax_image = ~img;
      end
      if (disturb && cyc == done_c) start = 1'b1;

      n_idx = -1;
      for (int n = 0; n < ks.size(); n++)
        if (cyc >= vs[n] && cyc <= hs[n]) n_idx = n;
      out_ready = (n_idx >= 0 && cyc < hs[n_idx]) ? 1'b0 : 1'b1;

      check("out_valid", out_valid, (n_idx >= 0) ? 1 : 0);
      if (n_idx >= 0) begin
        check("out_i", out_i, ks[n_idx] / N);
        check("out_j", out_j, ks[n_idx] % N);
        check("out_last", out_last, (n_idx == ks.size() - 1) ? 1 : 0);
        if (cyc == hs[n_idx])
          $display("beat %0d: i=%0d j=%0d last=%0b cycle=%0d", n_idx, out_i, out_j, out_last, cyc);
      end
      check("busy", busy, (cyc >= t + 1 && cyc <= done_c) ? 1 : 0);
      check("frame_done", frame_done, (cyc == done_c) ? 1 : 0);
`ifdef REGMAX_COORD_COUNT_EN
      if (cyc == done_c + 1) check("max_count", max_count, ks.size());
`endif
    end while (cyc < done_c + 1);
    start = 1'b0;
    $display("frame start=%0d beats=%0d done=%0d", t, ks.size(), done_c);
  endtask

  initial begin
    logic [63:0] img;
    reset        = 1'b1;
    start        = 1'b0;
    out_ready    = 1'b1;
    regmax_image = '0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_j", out_j, 0);
    check("rst_out_last", out_last, 0);
    reset = 1'b0;
    step();

    // Empty frame
    run_frame(64'd0, 0, 1'b0);
    // Single bit (2,5), no backpressure
    img = 64'd0; img[2*N+5] = 1'b1;
    run_frame(img, 0, 1'b0);
    // (0,0), (0,1), (7,7) with stalls
    img = 64'd0; img[0] = 1'b1; img[1] = 1'b1; img[63] = 1'b1;
    run_frame(img, 5, 1'b0);
    // All ones
    run_frame({64{1'b1}}, 0, 1'b0);
    // Random frames with random backpressure
    for (int r = 0; r < 4; r++) begin
      img = {$urandom, $urandom} & {$urandom, $urandom};
      run_frame(img, 3, 1'b0);
    end
    // Start and image changes mid-frame, start during frame_done
    img = {$urandom, $urandom};
    run_frame(img, 2, 1'b1);

    // Reset while a beat is held under backpressure
    img = 64'd0; img[3*N+4] = 1'b1; img[5*N+1] = 1'b1;
    regmax_image = img;
    start        = 1'b1;
    out_ready    = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 30; c++) step();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_i", out_i, 3);
    check("pre_rst_j", out_j, 4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_i", out_i, 0);
    check("async_rst_j", out_j, 0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_frame_done", frame_done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", out_valid, 0);
    end
    // Fresh frame after the abort
    run_frame(img, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
